// File: rtl/delay_line_ctrl.sv
// Circular audio delay-line sequencer driving a simple dual-port sample RAM.
// Each accepted sample takes three cycles: read the delayed word, write the new word, emit.
module delay_line_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] delay,
   input  logic                  sample_in_valid,
   input  logic [DATA_WIDTH-1:0] sample_in,
   output logic                  sample_in_ready,
   output logic                  sample_out_valid,
   output logic [DATA_WIDTH-1:0] sample_out,
   output logic                  ram_wr,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_rd,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

   localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(RAM_DEPTH - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] fill_cnt;
   logic [ADDR_WIDTH-1:0] dly_lat;
   logic [DATA_WIDTH-1:0] smp_lat;
   logic                  wr_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      sample_in_ready  = 1'b0;
      sample_out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            sample_in_ready = 1'b1;
            if (sample_in_valid) state_nxt = RD;
         end
         RD:  state_nxt = OUT;
         OUT: begin
            sample_out_valid = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   // The write strobe is registered, so clear must also mask it combinationally in its own cycle.
   assign ram_wr = wr_q & ~clear;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         fill_cnt    <= '0;
         dly_lat     <= '0;
         smp_lat     <= '0;
         wr_q        <= 1'b0;
         ram_rd      <= 1'b0;
         ram_rd_addr <= '0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
         sample_out  <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
         wr_q     <= 1'b0;
         ram_rd   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               wr_q <= 1'b0;
               if (sample_in_valid) begin
                  smp_lat     <= sample_in;
                  dly_lat     <= delay;
                  ram_rd_addr <= wr_ptr - delay;
                  ram_rd      <= 1'b1;
               end
            end
            RD: begin
               if (dly_lat == '0)            sample_out <= smp_lat;
               else if (fill_cnt < dly_lat)  sample_out <= '0;
               else                          sample_out <= ram_rd_data;
               wr_q        <= 1'b1;
               ram_wr_addr <= wr_ptr;
               ram_wr_data <= smp_lat;
               ram_rd      <= 1'b0;
               wr_ptr      <= wr_ptr + 1'b1;
               if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
            end
            OUT: begin
               wr_q <= 1'b0;
            end
            default: begin
               wr_q   <= 1'b0;
               ram_rd <= 1'b0;
            end
         endcase
      end
   end

endmodule
